// File: rtl/axis_pkg.sv
// Shared types and helpers for the sfifo -> AXI4-Stream drain stage.
//   occ_t       occupancy of the 2-entry output buffer (0..2)
//   clog2_min1  ceil(log2(n)), clamped to at least 1, for counter widths
package axis_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_to_axis_if.sv
// Bundles the sfifo read side and the AXI4-Stream master side of fifo_to_axis.
//   fifo_out, fifo_empty, fifo_rd_en          sfifo read interface
//   m_axis_tdata/tvalid/tlast, m_axis_tready  AXI4-Stream
// master: the drain stage's view; slave: the environment (sfifo + consumer).
interface fifo_to_axis_if #(
    parameter int num_data_bits = 32
);
    logic [num_data_bits-1:0] fifo_out;
    logic                     fifo_empty;
    logic                     fifo_rd_en;
    logic [num_data_bits-1:0] m_axis_tdata;
    logic                     m_axis_tvalid;
    logic                     m_axis_tlast;
    logic                     m_axis_tready;

    modport master (
        input  fifo_out, fifo_empty, m_axis_tready,
        output fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output fifo_out, fifo_empty, m_axis_tready,
        input  fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/skid_buf2.sv
// Two-entry in-order register buffer.
//   clk, reset  clock and synchronous active-high reset
//   i_push      write i_din at the tail this edge
//   i_pop       drop the head this edge (caller guarantees o_occ != 0)
//   o_dout      head word
//   o_occ       number of words held (0..2)
// The caller never pushes into a full buffer unless it pops in the same cycle.
module skid_buf2
    import axis_pkg::*;
#(
    parameter int num_data_bits = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [num_data_bits-1:0] i_din,
    output logic [num_data_bits-1:0] o_dout,
    output occ_t                     o_occ
);

    logic [num_data_bits-1:0] r_head;
    logic [num_data_bits-1:0] r_tail;
    occ_t                     r_occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= OCC_EMPTY;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == OCC_EMPTY) r_head <= i_din;
                    else                    r_tail <= i_din;
                    r_occ <= r_occ + OCC_ONE;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - OCC_ONE;
                end
                2'b11: begin
                    // Occupancy unchanged: head advances, new word lands behind it.
                    if (r_occ == OCC_ONE) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dout = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_to_axis.sv
// Drains a registered-read sfifo into an AXI4-Stream master.
//   clk, reset  single clock, synchronous active-high reset (shared with the sfifo)
//   bus         fifo_to_axis_if.master: fifo_out/fifo_empty in, fifo_rd_en out,
//               m_axis_tdata/tvalid/tlast out, m_axis_tready in
// A read is issued whenever the sfifo has data and the word it returns next cycle
// is guaranteed a slot in the 2-entry buffer; this sustains one beat per clock.
// tlast marks every pkt_len-th beat (pkt_len = 0 disables it).
module fifo_to_axis
    import axis_pkg::*;
#(
    parameter int num_data_bits = 32,
    parameter int pkt_len       = 16
) (
    input  logic           clk,
    input  logic           reset,
    fifo_to_axis_if.master bus
);

    localparam int CNT_W = clog2_min1(pkt_len);

    logic                     r_inflight;
    logic [CNT_W-1:0]         r_beat_cnt;
    occ_t                     w_occ;
    logic [num_data_bits-1:0] w_head;
    logic                     w_tvalid;
    logic                     w_pop;
    logic                     w_rd_en;
    logic                     w_last;
    logic [2:0]               w_fill;

    assign w_tvalid = (w_occ != OCC_EMPTY);
    assign w_pop    = w_tvalid && bus.m_axis_tready;

    // Words that will be held after this edge if nothing new is read.
    // Depends on tready, so tready -> fifo_rd_en is a combinational path.
    assign w_fill  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = !reset && !bus.fifo_empty && (w_fill < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    skid_buf2 #(
        .num_data_bits(num_data_bits)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_din  (bus.fifo_out),
        .o_dout (w_head),
        .o_occ  (w_occ)
    );

    generate
        if (pkt_len == 0) begin : g_no_last
            assign w_last = 1'b0;
        end else begin : g_last
            assign w_last = (r_beat_cnt == CNT_W'(pkt_len - 1));
        end
    endgenerate

    // Beat counter only moves on accepted beats, so it survives source gaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
        end
    end

    assign bus.fifo_rd_en    = w_rd_en;
    assign bus.m_axis_tdata  = w_head;
    assign bus.m_axis_tvalid = w_tvalid;
    assign bus.m_axis_tlast  = w_tvalid && w_last;

endmodule

// File: tb/tb_fifo_to_axis.sv
module tb_fifo_to_axis;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        tready;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three identical sfifo(8) -> fifo_to_axis chains, differing only in pkt_len:
    // g[0]: 4, g[1]: 0, g[2]: 1.  All see the same writes and tready.
    for (genvar k = 0; k < 3; k++) begin : g
        localparam int PL = (k == 0) ? 4 : ((k == 1) ? 0 : 1);

        fifo_to_axis_if #(.num_data_bits(32)) bus ();

        logic [31:0] mem [8];
        logic [3:0]  cnt;
        logic [2:0]  rp;
        logic [2:0]  wp;
        logic        do_rd;
        logic        do_wr;

        assign do_rd             = bus.fifo_rd_en && (cnt != 4'd0);
        assign do_wr             = wr_en && (cnt != 4'd8);
        assign bus.fifo_empty    = (cnt == 4'd0);
        assign bus.m_axis_tready = tready;

        always @(posedge clk) begin
            if (rst) begin
                cnt          <= 4'd0;
                rp           <= 3'd0;
                wp           <= 3'd0;
                bus.fifo_out <= 32'h0;
            end else begin
                if (do_wr) begin
                    mem[wp] <= wr_data;
                    wp      <= wp + 3'd1;
                end
                if (do_rd) begin
                    bus.fifo_out <= mem[rp];
                    rp           <= rp + 3'd1;
                end
                cnt <= cnt + {3'b000, do_wr} - {3'b000, do_rd};
            end
        end

        fifo_to_axis #(
            .num_data_bits(32),
            .pkt_len      (PL)
        ) dut (
            .clk  (clk),
            .reset(rst),
            .bus  (bus)
        );
    end

    logic        tv, tl0, tl1, tl2, rd0, emp0;
    logic [31:0] td;
    assign tv   = g[0].bus.m_axis_tvalid;
    assign td   = g[0].bus.m_axis_tdata;
    assign tl0  = g[0].bus.m_axis_tlast;
    assign tl1  = g[1].bus.m_axis_tlast;
    assign tl2  = g[2].bus.m_axis_tlast;
    assign rd0  = g[0].bus.fifo_rd_en;
    assign emp0 = g[0].bus.fifo_empty;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        wr_en  = 1'b1;
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 32'hDEAD_0000 + i;
            @(negedge clk);
            n_tests++;
            if (tv !== 1'b0 || td !== 32'h0 || tl0 !== 1'b0 || rd0 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: tvalid=%b tdata=%h tlast=%b rd_en=%b, required 0 0 0 0",
                         i, tv, td, tl0, rd0);
            end
            tick();
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (tv !== 1'b0 || rd0 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_after cyc%0d: tvalid=%b rd_en=%b, required 0 0", i, tv, rd0);
            end
            tick();
        end
    endtask

    task automatic test_throughput();
        logic exp_last;
        tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        repeat (4) tick();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_last = (i % 4 == 3);
            @(negedge clk);
            n_tests++;
            if (tv !== 1'b1 || td !== 32'(i + 1) || tl0 !== exp_last) begin
                n_fail++;
                $display("FAIL throughput beat%0d: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                         i, tv, td, tl0, 32'(i + 1), exp_last);
            end
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (tv !== 1'b0) begin
            n_fail++;
            $display("FAIL throughput_drained: tvalid=%b, required 0", tv);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] pat;
        int          nw;
        int          nb;
        logic        pv;
        logic        pr;
        logic        pl;
        logic [31:0] pd;
        pat = 32'b1011_0010_0110_1101_0100_1110_0011_0101;
        nw  = 0;
        nb  = 0;
        pv  = 1'b0;
        pr  = 1'b0;
        pl  = 1'b0;
        pd  = 32'h0;
        for (int c = 0; c < 200 && nb < 8; c++) begin
            wr_en   = (nw < 8);
            wr_data = 32'h10 + nw;
            if (nw < 8) nw++;
            tready = pat[c % 32];
            @(negedge clk);
            n_tests++;
            if (rd0 === 1'b1 && emp0 === 1'b1) begin
                n_fail++;
                $display("FAIL bp_rd_while_empty cyc%0d: rd_en=%b empty=%b, required rd_en 0", c, rd0, emp0);
            end
            if (pv && !pr) begin
                n_tests++;
                if (tv !== 1'b1 || td !== pd || tl0 !== pl) begin
                    n_fail++;
                    $display("FAIL bp_stall_hold cyc%0d: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                             c, tv, td, tl0, pd, pl);
                end
            end
            if (tv === 1'b1 && tready) begin
                n_tests++;
                if (td !== 32'h10 + nb || tl0 !== (nb % 4 == 3)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: tdata=%h tlast=%b, required %h %b",
                             nb, td, tl0, 32'h10 + nb, (nb % 4 == 3));
                end
                nb++;
            end
            pv = tv;
            pr = tready;
            pd = td;
            pl = tl0;
            tick();
        end
        wr_en = 1'b0;
        n_tests++;
        if (nb != 8) begin
            n_fail++;
            $display("FAIL bp_beat_count: beats=%0d, required 8", nb);
        end
        tready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (tv !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: tvalid=%b tdata=%h, required tvalid 0", tv, td);
        end
        tick();
    endtask

    task automatic test_latency();
        tready  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'hA5;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rd0 !== 1'b1 || tv !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_n1: rd_en=%b tvalid=%b, required 1 0", rd0, tv);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (tv !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_n2: tvalid=%b, required 0", tv);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (tv !== 1'b1 || td !== 32'hA5) begin
            n_fail++;
            $display("FAIL latency_n3: tvalid=%b tdata=%h, required 1 000000a5", tv, td);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (tv !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_n4: tvalid=%b, required 0", tv);
        end
        tick();
    endtask

    task automatic test_tlast();
        int nw;
        int nb;
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        tready = 1'b1;
        nw     = 0;
        nb     = 0;
        for (int c = 0; c < 80 && nb < 10; c++) begin
            wr_en = (nw < 10) && (c % 3 == 0);
            if (wr_en) begin
                wr_data = 32'h20 + nw;
                nw++;
            end
            @(negedge clk);
            if (tv === 1'b1) begin
                nb++;
                n_tests++;
                if (td !== 32'h20 + nb - 1 || tl0 !== (nb == 4 || nb == 8) || tl1 !== 1'b0 || tl2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tlast_beat%0d: tdata=%h last4=%b last0=%b last1=%b, required %h %b 0 1",
                             nb, td, tl0, tl1, tl2, 32'h20 + nb - 1, (nb == 4 || nb == 8));
                end
            end
            tick();
        end
        wr_en = 1'b0;
        n_tests++;
        if (nb != 10) begin
            n_fail++;
            $display("FAIL tlast_beat_count: beats=%0d, required 10", nb);
        end
    endtask

    task automatic test_reset_midstream();
        int nw;
        int nb;
        tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h30 + i;
            tick();
        end
        wr_en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if (tv !== 1'b1 || td !== 32'h30) begin
            n_fail++;
            $display("FAIL mid_stall: tvalid=%b tdata=%h, required 1 00000030", tv, td);
        end
        tick();
        tready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rd0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_refill: rd_en=%b, required 1", rd0);
        end
        tick();
        tready = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rd0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rd_in_reset: rd_en=%b, required 0", rd0);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (tv !== 1'b0 || td !== 32'h0 || tl0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_cleared: tvalid=%b tdata=%h tlast=%b, required 0 0 0", tv, td, tl0);
        end
        tick();
        rst    = 1'b0;
        tready = 1'b1;
        nw     = 0;
        nb     = 0;
        for (int c = 0; c < 40 && nb < 4; c++) begin
            wr_en   = (nw < 4);
            wr_data = 32'h40 + nw;
            if (nw < 4) nw++;
            @(negedge clk);
            if (tv === 1'b1) begin
                n_tests++;
                if (td !== 32'h40 + nb || tl0 !== (nb == 3) || tl2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_restart_beat%0d: tdata=%h last4=%b last1=%b, required %h %b 1",
                             nb, td, tl0, tl2, 32'h40 + nb, (nb == 3));
                end
                nb++;
            end
            tick();
        end
        wr_en = 1'b0;
        n_tests++;
        if (nb != 4) begin
            n_fail++;
            $display("FAIL mid_restart_count: beats=%0d, required 4", nb);
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 32'h0;
        tready  = 1'b0;
        test_reset();
        test_throughput();
        test_backpressure();
        test_latency();
        test_tlast();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
